// File: rtl/axi_mem_responder.sv
// AXI4 slave memory model answering LLC fills and writebacks: independent read and
// write channel FSMs, one outstanding transaction each, sharing one word array.
module axi_mem_responder #(
  parameter int ID_WIDTH     = 13,
  parameter int ADDR_WIDTH   = 64,
  parameter int DATA_WIDTH   = 64,
  parameter int MEM_WORDS    = 4096,
  parameter int READ_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int IW = $clog2(MEM_WORDS);
  localparam int SW = DATA_WIDTH / 8;
  localparam logic [3:0] RLAT = READ_LATENCY[3:0];
  localparam logic [1:0] BURST_WRAP = 2'b10;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_WAIT  = 2'd1;
  localparam logic [1:0] R_BURST = 2'd2;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  // Legal WRAP lengths wrap the low index bits inside an aligned block; anything else walks up.
  function automatic logic [IW-1:0] beat_index(input logic [IW-1:0] start,
                                               input logic [7:0]    len,
                                               input logic [1:0]    burst,
                                               input logic [7:0]    beat);
    logic [IW-1:0] step;
    logic [IW-1:0] mask;
    step = IW'(beat);
    mask = IW'(len[3:0]);
    if (burst == BURST_WRAP &&
        (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
      return (start & ~mask) | ((start + step) & mask);
    return start + step;
  endfunction

  // Read channel
  logic [1:0]    r_state;
  logic [3:0]    r_cnt;
  logic [IW-1:0] ar_word;
  logic [7:0]    ar_len;
  logic [1:0]    ar_burst;
  logic [7:0]    r_beat;
  logic [7:0]    r_beat_next;

  assign r_beat_next   = r_beat + 8'd1;
  assign s_axi_arready = (r_state == R_IDLE);
  assign s_axi_rresp   = 2'b00;

  // NOTE: state is updated with non-blocking assignments so every register samples
  // pre-edge values; that is also what gives a same-cycle read its pre-write data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= R_IDLE;
      r_cnt        <= '0;
      ar_word      <= '0;
      ar_len       <= '0;
      ar_burst     <= '0;
      r_beat       <= '0;
      s_axi_rid    <= '0;
      s_axi_rdata  <= '0;
      s_axi_rlast  <= 1'b0;
      s_axi_rvalid <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s_axi_arvalid) begin
            s_axi_rid <= s_axi_arid;
            ar_word   <= s_axi_araddr[IW+2:3];
            ar_len    <= s_axi_arlen;
            ar_burst  <= s_axi_arburst;
            r_beat    <= '0;
            r_cnt     <= RLAT;
            r_state   <= (RLAT == 4'd0) ? R_BURST : R_WAIT;
          end
        end
        R_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt <= 4'd1) r_state <= R_BURST;
        end
        R_BURST: begin
          if (!s_axi_rvalid) begin
            // First beat of the burst is fetched on entry
            s_axi_rdata  <= mem[beat_index(ar_word, ar_len, ar_burst, r_beat)];
            s_axi_rlast  <= (r_beat == ar_len);
            s_axi_rvalid <= 1'b1;
          end else if (s_axi_rready) begin
            if (s_axi_rlast) begin
              s_axi_rvalid <= 1'b0;
              s_axi_rlast  <= 1'b0;
              r_state      <= R_IDLE;
            end else begin
              s_axi_rdata <= mem[beat_index(ar_word, ar_len, ar_burst, r_beat_next)];
              s_axi_rlast <= (r_beat_next == ar_len);
              r_beat      <= r_beat_next;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Write channel
  logic [1:0]    w_state;
  logic [IW-1:0] aw_word;
  logic [7:0]    aw_len;
  logic [1:0]    aw_burst;
  logic [7:0]    w_beat;
  logic          w_err;
  logic          w_fire;
  logic          w_last_beat;
  logic          w_err_next;
  logic          w_done;
  logic [IW-1:0] w_index;

  assign s_axi_awready = (w_state == W_IDLE);
  assign s_axi_wready  = (w_state == W_DATA);
  assign s_axi_bvalid  = (w_state == W_RESP);
  assign w_fire        = s_axi_wready && s_axi_wvalid;
  assign w_last_beat   = (w_beat == aw_len);
  // wlast early or missing on the final beat both show up as a mismatch
  assign w_err_next    = w_err | (s_axi_wlast ^ w_last_beat);
  assign w_done        = s_axi_wlast | w_last_beat;
  assign w_index       = beat_index(aw_word, aw_len, aw_burst, w_beat);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_state     <= W_IDLE;
      aw_word     <= '0;
      aw_len      <= '0;
      aw_burst    <= '0;
      w_beat      <= '0;
      w_err       <= 1'b0;
      s_axi_bid   <= '0;
      s_axi_bresp <= 2'b00;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (s_axi_awvalid) begin
            s_axi_bid <= s_axi_awid;
            aw_word   <= s_axi_awaddr[IW+2:3];
            aw_len    <= s_axi_awlen;
            aw_burst  <= s_axi_awburst;
            w_beat    <= '0;
            w_err     <= 1'b0;
            w_state   <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_err  <= w_err_next;
            w_beat <= w_beat + 8'd1;
            if (w_done) begin
              s_axi_bresp <= w_err_next ? 2'b10 : 2'b00;
              w_state     <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // NOTE: the array has no reset so its contents survive reset and it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_fire) begin
      for (int b = 0; b < SW; b++) begin
        if (s_axi_wstrb[b]) mem[w_index][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  // Address bits outside the word index alias by design
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr[ADDR_WIDTH-1:IW+3], s_axi_awaddr[2:0],
                              s_axi_araddr[ADDR_WIDTH-1:IW+3], s_axi_araddr[2:0]};

endmodule
